jtkcpu_busresp: RTL and testbench
=================================

// Module: jtkcpu_busresp
// PURPOSE
// Bus responder for the jtkcpu memory interface: answers CPU cycles on as/we/addr/dout.
// Serves an internal byte RAM plus one control register, inserts wait states and drives dtack.
// Generates a periodic irq to the CPU.
// Used as the CPU's test/system-side target and as a template for game-board memory maps.
// PARAMETERS
// RAM_AW    12        RAM address width; RAM holds 2**RAM_AW bytes
// RAM_BASE  24'h0000  RAM base address, aligned to 2**RAM_AW
// IO_ADDR   24'hFF00  address of the control register
// WAITS     0         extra cen ticks inserted before dtack, 0..15
// PERIOD    1024      irq timer period in cen ticks, >=2
// TIMEOUT   32        cen ticks before an unmapped access is force-acked
// PORTS
// clk       in   1   system clock
// rst       in   1   synchronous reset, active high
// cen       in   1   CPU clock enable; all state advances only when cen=1 (except rst)
// as        in   1   address strobe from CPU, active high
// we        in   1   write enable from CPU, sampled with as
// addr      in   24  CPU address
// cpu_dout  in   8   write data from CPU
// cpu_din   out  8   read data to CPU
// dtack     out  1   data acknowledge to CPU, active high
// irq       out  1   interrupt request to CPU, active high, level
// bus_err   out  1   sticky flag: unmapped access was force-acked
// BEHAVIOUR
// - rst (sync, on clk, ignores cen): FSM=IDLE; dtack=0, cpu_din=0, irq=0, bus_err=0; irq_en=0, counters=0.
//   RAM contents are not cleared. rst mid-cycle abandons any access; no RAM write occurs.
// - Decode on latched address: RAM hit if addr[23:RAM_AW]==RAM_BASE[23:RAM_AW]; IO hit if addr==IO_ADDR.
//   Anything else is a miss.
// - FSM, evaluated on cen:
//   IDLE: as=1 -> latch addr/we/cpu_dout, wcnt<=WAITS, tcnt<=0 -> WAIT.
//   WAIT: as=0 -> IDLE (abort, no side effects).
//         hit and wcnt==0 -> perform access, dtack<=1 -> ACK. A read loads cpu_din in the same cen.
//         hit and wcnt!=0 -> wcnt<=wcnt-1.
//         miss -> see CONFIGURATION.
//   ACK:  hold dtack=1 and cpu_din until as=0 is sampled, then dtack<=0 -> IDLE.
//         A new cycle always passes through IDLE.
// - Latency: dtack rises WAITS+1 cen ticks after the cen that first samples as=1.
// - RAM write: mem[addr[RAM_AW-1:0]]<=cpu_dout. RAM read: cpu_din<=mem[addr[RAM_AW-1:0]].
// - IO read: cpu_din={5'b0,bus_err,irq,irq_en}.
// - IO write bits:
//   bit0 -> irq_en.
//   bit1=1 clears irq.
//   bit2=1 clears bus_err.
// - Timer:
//   irq_en=0: tmr held at 0.
//   irq_en=1: tmr counts 0..PERIOD-1 per cen and wraps; the wrap sets irq.
//   A tick and a bit1 clear in the same cen: set wins, irq stays 1.
//   irq stays high until cleared; further ticks while irq=1 are absorbed.
// CONFIGURATION
// - JTKCPU_BUSRESP_TIMEOUT_EN defined:
//   On a miss in WAIT, tcnt increments per cen.
//   When tcnt==TIMEOUT-1: dtack<=1, cpu_din<=8'hFF, bus_err<=1 -> ACK. Misses do no writes.
// - Not defined: a miss never acks. FSM stays in WAIT until as=0 -> IDLE.
//   bus_err is tied 0 and tcnt is not built.
// TESTING
// 1. WAITS=2, write 8'h5A to RAM_BASE+3, then read it
//    -> dtack rises on the 3rd cen after as sampled; read cpu_din=8'h5A.
// 2. PERIOD=16, write IO_ADDR 8'h01 -> irq=1 on the 16th cen after the write acks;
//    write 8'h03 -> irq=0 and rises again 16 cen later.
// 3. Clear write (8'h03) coinciding with the timer wrap cen -> irq remains 1.
// 4. Read 24'hFFFFFF -> with macro and TIMEOUT=32: dtack after 32 cen in WAIT, cpu_din=8'hFF,
//    bus_err=1, IO read=8'h04+flags; without macro: dtack=0 for 1000 cen, IDLE once as=0.
// 5. Assert rst during WAIT of a write 8'hA5 to RAM_BASE -> dtack=0 next clk, RAM byte unchanged.
// 6. Drop as during WAIT of a RAM write -> FSM IDLE, no write; next read returns the old value.

Source files
------------

// File: rtl/jtkcpu_busresp.sv
// jtkcpu bus responder: byte RAM, control register, wait states and a periodic irq.
// Optional JTKCPU_BUSRESP_TIMEOUT_EN force-acks unmapped accesses and sets bus_err.
module jtkcpu_busresp #(
    parameter int          RAM_AW   = 12,
    parameter logic [23:0] RAM_BASE = 24'h0000,
    parameter logic [23:0] IO_ADDR  = 24'hFF00,
    parameter int          WAITS    = 0,
    parameter int          PERIOD   = 1024,
    parameter int          TIMEOUT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        as,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        dtack,
    output logic        irq,
    output logic        bus_err
);

    localparam int TW = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      st, st_nxt;
    logic [23:0] addr_l;
    logic        we_l;
    logic [7:0]  dout_l;
    logic [3:0]  wcnt;
    logic [TW-1:0] tmr;
    logic        irq_en;
    logic [7:0]  mem [0:2**RAM_AW-1];

    logic ram_hit, io_hit, ram_sel, hit;
    logic do_acc, tmo, ram_we, io_we, in_wait;

    assign ram_hit = addr_l[23:RAM_AW] == RAM_BASE[23:RAM_AW];
    assign io_hit  = addr_l == IO_ADDR;
    assign ram_sel = ram_hit && !io_hit;
    assign hit     = ram_hit || io_hit;
    assign in_wait = cen && st == WAIT && as;
    assign do_acc  = in_wait && hit && wcnt == 4'd0;
    assign ram_we  = do_acc && ram_sel && we_l && !rst;
    assign io_we   = do_acc && io_hit && we_l;

`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt;
    logic          err_q;

    assign tmo     = in_wait && !hit && tcnt == CW'(TIMEOUT - 1);
    assign bus_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else if (cen) begin
            if (st == IDLE && as)
                tcnt <= '0;
            else if (in_wait && !hit && !tmo)
                tcnt <= tcnt + CW'(1);
            if (tmo)
                err_q <= 1'b1;
            else if (io_we && dout_l[2])
                err_q <= 1'b0;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE: if (cen && as) st_nxt = WAIT;
            WAIT: begin
                if (cen && !as)        st_nxt = IDLE;
                else if (do_acc || tmo) st_nxt = ACK;
            end
            ACK:  if (cen && !as) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // RAM is never reset; a reset in the access cycle suppresses the write
    always_ff @(posedge clk) begin
        if (ram_we) mem[addr_l[RAM_AW-1:0]] <= dout_l;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_l  <= '0;
            we_l    <= 1'b0;
            dout_l  <= '0;
            wcnt    <= '0;
            dtack   <= 1'b0;
            cpu_din <= '0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
            tmr     <= '0;
        end else if (cen) begin
            if (st == IDLE && as) begin
                addr_l <= addr;
                we_l   <= we;
                dout_l <= cpu_dout;
                wcnt   <= 4'(WAITS);
            end
            if (in_wait && hit && wcnt != 4'd0)
                wcnt <= wcnt - 4'd1;
            if (do_acc) begin
                dtack <= 1'b1;
                if (!we_l)
                    cpu_din <= io_hit ? {5'b0, bus_err, irq, irq_en}
                                      : mem[addr_l[RAM_AW-1:0]];
            end
            if (tmo) begin
                dtack   <= 1'b1;
                cpu_din <= 8'hFF;
            end
            if (st == ACK && !as)
                dtack <= 1'b0;
            if (io_we) begin
                irq_en <= dout_l[0];
                if (dout_l[1]) irq <= 1'b0;
            end
            // a wrap in the same cen as a clear leaves irq set
            if (!irq_en) begin
                tmr <= '0;
            end else if (tmr == TW'(PERIOD - 1)) begin
                tmr <= '0;
                irq <= 1'b1;
            end else begin
                tmr <= tmr + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// Self-checking bench for jtkcpu_busresp: vector table, corner sequences, random traffic.
// Reference model works per bus transaction and per cen tick with plain arithmetic.
module tb_jtkcpu_busresp;

    localparam int          WAITS   = 2;
    localparam int          PERIOD  = 16;
    localparam int          TIMEOUT = 32;
    localparam logic [23:0] IO      = 24'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        as  = 1'b0;
    logic        we  = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        dtack, irq, bus_err;

    jtkcpu_busresp #(
        .RAM_AW(12), .RAM_BASE(24'h0000), .IO_ADDR(IO),
        .WAITS(WAITS), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen), .as(as), .we(we),
        .addr(addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .dtack(dtack), .irq(irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] m_mem [int];
    bit   m_en, m_irq, m_err;
    int   m_cnt;
    int   g_cen;
    int   g_ack;
    logic [7:0] last_rd;

    typedef struct {
        bit          w;
        logic [23:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_ram(input logic [23:0] a);
        return a[23:12] == 12'h000;
    endfunction

    task automatic model_reset();
        m_en = 0; m_irq = 0; m_err = 0; m_cnt = 0;
    endtask

    // one cen tick, preceded by 0..2 clocks with cen low
    task automatic step(input bit acc, input bit w, input logic [23:0] a,
                        input logic [7:0] d, output logic [7:0] rd);
        bit tick;
        repeat ($urandom_range(0, 2)) begin
            cen = 1'b0;
            @(posedge clk); #1;
        end
        cen = 1'b1;
        @(posedge clk); #1;
        cen = 1'b0;
        g_cen++;
        tick = m_en && (m_cnt % PERIOD == PERIOD - 1);
        if (m_en) m_cnt++;
        else      m_cnt = 0;
        rd = 8'h00;
        if (acc) begin
            if (a == IO) begin
                if (w) begin
                    m_en = d[0];
                    if (d[1]) m_irq = 0;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
                    if (d[2]) m_err = 0;
`endif
                end else begin
                    rd = {5'b0, m_err, m_irq, m_en};
                end
            end else if (is_ram(a)) begin
                if (w) m_mem[int'(a[11:0])] = d;
                else   rd = m_mem[int'(a[11:0])];
            end else begin
                rd = 8'hFF;
                m_err = 1;
            end
        end
        if (tick) m_irq = 1;
        chk("irq_model", irq, m_irq);
        chk("buserr_model", bus_err, m_err);
    endtask

    task automatic tick0();
        logic [7:0] rd;
        step(1'b0, 1'b0, 24'h0, 8'h0, rd);
    endtask

    task automatic bus(input bit w, input logic [23:0] a, input logic [7:0] d);
        logic [7:0] rd, exp;
        int lat, first;
        lat = (a == IO || is_ram(a)) ? WAITS + 1 : TIMEOUT;
        first = -1;
        exp = 8'h00;
        as = 1'b1; we = w; addr = a; cpu_dout = d;
        for (int k = 0; k <= lat; k++) begin
            step(k == lat, w, a, d, rd);
            if (k == lat) begin
                exp = rd;
                g_ack = g_cen;
            end
            if (dtack && first < 0) first = k;
        end
        chk("latency", first, lat);
        if (!w) chk("read_data", cpu_din, exp);
        last_rd = cpu_din;
        repeat ($urandom_range(0, 2)) begin
            tick0();
            chk("ack_hold", dtack, 1'b1);
            chk("data_hold", cpu_din, last_rd);
        end
        as = 1'b0;
        tick0();
        chk("ack_drop", dtack, 1'b0);
    endtask

    vec_t vt [11];
    int   g_rise;
    bit   seen;
    logic [7:0] rd;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        g_cen = 0;
        g_ack = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_dtack", dtack, 1'b0);
        chk("rst_din", cpu_din, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_err", bus_err, 1'b0);

        vt[0]  = '{1'b1, 24'h000003, 8'h5A, 8'h00};
        vt[1]  = '{1'b0, 24'h000003, 8'h00, 8'h5A};
        vt[2]  = '{1'b1, 24'h000FFF, 8'hC3, 8'h00};
        vt[3]  = '{1'b0, 24'h000FFF, 8'h00, 8'hC3};
        vt[4]  = '{1'b1, 24'h000000, 8'h11, 8'h00};
        vt[5]  = '{1'b1, 24'h000005, 8'h22, 8'h00};
        vt[6]  = '{1'b0, 24'h000000, 8'h00, 8'h11};
        vt[7]  = '{1'b0, 24'h000005, 8'h00, 8'h22};
        vt[8]  = '{1'b0, IO,         8'h00, 8'h00};
        vt[9]  = '{1'b1, 24'h000003, 8'hA7, 8'h00};
        vt[10] = '{1'b0, 24'h000003, 8'h00, 8'hA7};
        foreach (vt[i]) begin
            bus(vt[i].w, vt[i].a, vt[i].d);
            if (!vt[i].w) chk("vec_read", last_rd, vt[i].exp);
        end

        // irq enable: first wrap 16 cen after the enabling write acks
        bus(1'b1, IO, 8'h01);
        while (!irq && g_cen - g_ack < 40) tick0();
        chk("irq_first", g_cen - g_ack, PERIOD);
        g_rise = g_cen;
        bus(1'b1, IO, 8'h03);
        chk("irq_cleared", irq, 1'b0);
        while (!irq && g_cen - g_rise < 40) tick0();
        chk("irq_again", g_cen - g_rise, PERIOD);

        // clear landing on the wrap cen
        while ((m_cnt + WAITS + 1) % PERIOD != PERIOD - 1) tick0();
        bus(1'b1, IO, 8'h03);
        chk("clr_vs_wrap", irq, 1'b1);
        bus(1'b1, IO, 8'h03);
        chk("clr_plain", irq, 1'b0);
        bus(1'b0, IO, 8'h00);
        chk("io_read_en", last_rd, 8'h01);

`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
        bus(1'b0, 24'hFFFFFF, 8'h00);
        chk("miss_data", last_rd, 8'hFF);
        chk("miss_err", bus_err, 1'b1);
        bus(1'b0, IO, 8'h00);
        chk("io_err_bit", last_rd & 8'h05, 8'h05);
        bus(1'b1, IO, 8'h05);
        chk("err_clear", bus_err, 1'b0);
`else
        seen = 1'b0;
        as = 1'b1; we = 1'b0; addr = 24'hFFFFFF;
        repeat (1000) begin
            tick0();
            if (dtack) seen = 1'b1;
        end
        chk("miss_noack", seen, 1'b0);
        as = 1'b0;
        tick0();
        chk("miss_err", bus_err, 1'b0);
        bus(1'b0, 24'h000003, 8'h00);
        chk("after_miss", last_rd, 8'hA7);
`endif

        // reset in the middle of a write
        as = 1'b1; we = 1'b1; addr = 24'h000000; cpu_dout = 8'hA5;
        tick0();
        tick0();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        as = 1'b0;
        model_reset();
        chk("rst_mid_dtack", dtack, 1'b0);
        chk("rst_mid_irq", irq, 1'b0);
        chk("rst_mid_din", cpu_din, 8'h00);
        bus(1'b0, 24'h000000, 8'h00);
        chk("rst_no_write", last_rd, 8'h11);

        // strobe dropped during wait states
        as = 1'b1; we = 1'b1; addr = 24'h000005; cpu_dout = 8'h77;
        tick0();
        tick0();
        as = 1'b0;
        tick0();
        chk("abort_dtack", dtack, 1'b0);
        bus(1'b0, 24'h000005, 8'h00);
        chk("abort_no_write", last_rd, 8'h22);

        for (int i = 0; i < 16; i++) begin
            bus(1'b1, 24'(i), 8'($urandom));
            bus(1'b1, 24'(12'hFF0 + i), 8'($urandom));
        end
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [23:0] a;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 1) ? 24'($urandom_range(0, 15))
                                     : 24'($urandom_range(12'hFF0, 12'hFFF));
            if (r == 0)
                bus(1'b1, IO, 8'($urandom));
            else if (r == 1)
                bus(1'b0, IO, 8'h00);
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
            else if (r == 9)
                bus(1'b0, 24'h123456, 8'h00);
`endif
            else
                bus(1'($urandom), a, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
